// File: rtl/rename_rat_ckpt_if.sv
// Rename-stage bus for rename_rat_ckpt: rename reads/writes, checkpoint
// handshake, mispredict restore, flush and commit ports.
interface rename_rat_ckpt_if #(
  parameter int PREG_W   = 7,
  parameter int AREG_NUM = 32,
  parameter int WIDTH    = 2,
  parameter int CKPT_NUM = 4
);
  localparam int AREG_W = $clog2(AREG_NUM);
  localparam int CKPT_W = $clog2(CKPT_NUM);

  logic [WIDTH-1:0][1:0][AREG_W-1:0] raddr_i;
  logic [WIDTH-1:0][1:0][PREG_W-1:0] rdata_o;
  logic [WIDTH-1:0]                  we_i;
  logic [WIDTH-1:0][AREG_W-1:0]      waddr_i;
  logic [WIDTH-1:0][PREG_W-1:0]      wdata_i;
  logic [WIDTH-1:0][PREG_W-1:0]      old_o;
  logic                              ckpt_req_i;
  logic                              ckpt_ready_o;
  logic [CKPT_W-1:0]                 ckpt_id_o;
  logic                              ckpt_rel_i;
  logic                              restore_i;
  logic [CKPT_W-1:0]                 restore_id_i;
  logic                              flush_i;
  logic [WIDTH-1:0]                  cmt_we_i;
  logic [WIDTH-1:0][AREG_W-1:0]      cmt_waddr_i;
  logic [WIDTH-1:0][PREG_W-1:0]      cmt_wdata_i;
  logic                              busy_o;

  modport master (
    output raddr_i, we_i, waddr_i, wdata_i, ckpt_req_i, ckpt_rel_i,
           restore_i, restore_id_i, flush_i, cmt_we_i, cmt_waddr_i, cmt_wdata_i,
    input  rdata_o, old_o, ckpt_ready_o, ckpt_id_o, busy_o
  );

  modport slave (
    input  raddr_i, we_i, waddr_i, wdata_i, ckpt_req_i, ckpt_rel_i,
           restore_i, restore_id_i, flush_i, cmt_we_i, cmt_waddr_i, cmt_wdata_i,
    output rdata_o, old_o, ckpt_ready_o, ckpt_id_o, busy_o
  );
endinterface

// File: rtl/rename_rat_ckpt.sv
// Speculative rename RAT with WIDTH-wide rename, intra-group forwarding,
// a FIFO of branch checkpoints for one-cycle restore, and a committed RAT
// used to rebuild the speculative table on flush.
// Build option RAT_FLUSH_CMT_BYPASS_EN: when defined, the flush copy merges
// same-cycle commits and recovery takes one cycle; otherwise the flush copy
// uses the pre-commit arch RAT and a second busy cycle re-copies it.
//
// state    | meaning
// IDLE     | normal renaming, checkpoints accepted
// RECOVER  | final recovery cycle, rename stalled
// RECOVER2 | first of two flush cycles, arch RAT re-copied into spec
module rename_rat_ckpt #(
  parameter int PREG_W   = 7,
  parameter int AREG_NUM = 32,
  parameter int WIDTH    = 2,
  parameter int CKPT_NUM = 4
) (
  input logic           clk,
  input logic           rst,
  rename_rat_ckpt_if.slave bus
);
  localparam int AREG_W = $clog2(AREG_NUM);
  localparam int CKPT_W = $clog2(CKPT_NUM);
  localparam logic [CKPT_W:0] CNT_FULL = (CKPT_W+1)'(CKPT_NUM);

  typedef enum logic [1:0] {IDLE, RECOVER, RECOVER2} state_t;
  typedef logic [AREG_NUM-1:0][PREG_W-1:0] rat_t;

  state_t state_q, state_d;
  rat_t spec_q, spec_d, spec_wr, arch_q, arch_d;
  rat_t ckpt_q [CKPT_NUM];
  logic [CKPT_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CKPT_W:0] cnt_q, cnt_d;
  logic alloc, rel;
  logic [WIDTH-1:0][1:0][PREG_W-1:0] rdata;
  logic [WIDTH-1:0][PREG_W-1:0] old;

  // Source and old-mapping lookup, forwarded from older slots in the group
  always_comb begin
    for (int k = 0; k < WIDTH; k++) begin
      for (int s = 0; s < 2; s++) begin
        rdata[k][s] = spec_q[bus.raddr_i[k][s]];
        for (int j = 0; j < k; j++)
          if (bus.we_i[j] && bus.waddr_i[j] == bus.raddr_i[k][s]) rdata[k][s] = bus.wdata_i[j];
      end
      old[k] = spec_q[bus.waddr_i[k]];
      for (int j = 0; j < k; j++)
        if (bus.we_i[j] && bus.waddr_i[j] == bus.waddr_i[k]) old[k] = bus.wdata_i[j];
    end
  end

  assign bus.rdata_o      = rdata;
  assign bus.old_o        = old;
  assign bus.ckpt_ready_o = (cnt_q != CNT_FULL);
  assign bus.ckpt_id_o    = tail_q;
  assign bus.busy_o       = (state_q != IDLE);

  // Next-state, table and checkpoint-pointer updates
  always_comb begin
    state_d = state_q;
    spec_d  = spec_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    alloc   = 1'b0;
    rel     = bus.ckpt_rel_i && (cnt_q != '0);
    spec_wr = spec_q;
    for (int j = 0; j < WIDTH; j++)
      if (bus.we_i[j]) spec_wr[bus.waddr_i[j]] = bus.wdata_i[j];
    arch_d = arch_q;
    for (int j = 0; j < WIDTH; j++)
      if (bus.cmt_we_i[j]) arch_d[bus.cmt_waddr_i[j]] = bus.cmt_wdata_i[j];

    if (bus.flush_i) begin
`ifdef RAT_FLUSH_CMT_BYPASS_EN
      spec_d  = arch_d;
      state_d = RECOVER;
`else
      spec_d  = arch_q;
      state_d = RECOVER2;
`endif
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      head_d = head_q + CKPT_W'(rel);
      case (state_q)
        IDLE: begin
          if (bus.restore_i) begin
            spec_d  = ckpt_q[bus.restore_id_i];
            tail_d  = bus.restore_id_i + CKPT_W'(1);
            // restore_id_i is live, so its distance from head is below cnt
            cnt_d   = {1'b0, CKPT_W'(bus.restore_id_i - head_d)} + (CKPT_W+1)'(1);
            state_d = RECOVER;
          end else begin
            spec_d = spec_wr;
            alloc  = bus.ckpt_req_i && (cnt_q != CNT_FULL);
            tail_d = tail_q + CKPT_W'(alloc);
            cnt_d  = cnt_q + (CKPT_W+1)'(alloc) - (CKPT_W+1)'(rel);
          end
        end
        RECOVER2: begin
          spec_d  = arch_q;
          cnt_d   = cnt_q - (CKPT_W+1)'(rel);
          state_d = RECOVER;
        end
        default: begin
          cnt_d   = cnt_q - (CKPT_W+1)'(rel);
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, tables and FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < AREG_NUM; i++) begin
        spec_q[i] <= PREG_W'(i);
        arch_q[i] <= PREG_W'(i);
      end
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      spec_q  <= spec_d;
      arch_q  <= arch_d;
    end
  end

  // Checkpoint storage: snapshot includes this cycle's rename writes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CKPT_NUM; c++)
        for (int i = 0; i < AREG_NUM; i++) ckpt_q[c][i] <= PREG_W'(i);
    end else if (alloc) begin
      ckpt_q[tail_q] <= spec_wr;
    end
  end
endmodule

// File: tb/tb_rename_rat_ckpt.sv
// Randomised and directed bench for rename_rat_ckpt against a queue-based
// reference model of the rename table, checkpoint FIFO and recovery timing.
module tb_rename_rat_ckpt;
  localparam int PREG_W   = 7;
  localparam int AREG_NUM = 32;
  localparam int WIDTH    = 2;
  localparam int CKPT_NUM = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rename_rat_ckpt_if #(.PREG_W(PREG_W), .AREG_NUM(AREG_NUM), .WIDTH(WIDTH), .CKPT_NUM(CKPT_NUM)) bus ();
  rename_rat_ckpt #(.PREG_W(PREG_W), .AREG_NUM(AREG_NUM), .WIDTH(WIDTH), .CKPT_NUM(CKPT_NUM)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef logic [PREG_W-1:0] rat_t [AREG_NUM];
  rat_t m_spec, m_arch;
  rat_t ck_q[$];
  int   ck_head;
  int   busy_left;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [PREG_W-1:0] fwd(input int k, input logic [4:0] a);
    for (int j = k - 1; j >= 0; j--)
      if (bus.we_i[j] && bus.waddr_i[j] == a) return bus.wdata_i[j];
    return m_spec[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < AREG_NUM; i++) begin
      m_spec[i] = PREG_W'(i);
      m_arch[i] = PREG_W'(i);
    end
    ck_q.delete();
    ck_head = 0;
    busy_left = 0;
  endtask

  task automatic check_outs();
    for (int k = 0; k < WIDTH; k++) begin
      for (int s = 0; s < 2; s++)
        chk($sformatf("rdata[%0d][%0d]", k, s), 32'(bus.rdata_o[k][s]), 32'(fwd(k, bus.raddr_i[k][s])));
      chk($sformatf("old[%0d]", k), 32'(bus.old_o[k]), 32'(fwd(k, bus.waddr_i[k])));
    end
    chk("ckpt_ready", 32'(bus.ckpt_ready_o), 32'(ck_q.size() < CKPT_NUM));
    chk("ckpt_id", 32'(bus.ckpt_id_o), 32'((ck_head + ck_q.size()) % CKPT_NUM));
    chk("busy", 32'(bus.busy_o), 32'(busy_left > 0));
  endtask

  task automatic model_update();
    rat_t an, sw;
    int   size0, idx;
    bit   rel_ok;
    if (rst) begin
      model_reset();
      return;
    end
    an = m_arch;
    for (int j = 0; j < WIDTH; j++)
      if (bus.cmt_we_i[j]) an[bus.cmt_waddr_i[j]] = bus.cmt_wdata_i[j];
    size0  = ck_q.size();
    rel_ok = bus.ckpt_rel_i && size0 > 0;
    if (bus.flush_i) begin
`ifdef RAT_FLUSH_CMT_BYPASS_EN
      m_spec = an;
      busy_left = 1;
`else
      m_spec = m_arch;
      busy_left = 2;
`endif
      ck_q.delete();
      ck_head = 0;
    end else begin
      if (rel_ok) begin
        void'(ck_q.pop_front());
        ck_head = (ck_head + 1) % CKPT_NUM;
      end
      if (busy_left > 0) begin
        if (busy_left == 2) m_spec = m_arch;
        busy_left--;
      end else if (bus.restore_i) begin
        idx = (int'(bus.restore_id_i) - ck_head + 2 * CKPT_NUM) % CKPT_NUM;
        if (idx < ck_q.size()) begin
          m_spec = ck_q[idx];
          while (ck_q.size() > idx + 1) void'(ck_q.pop_back());
        end
        busy_left = 1;
      end else begin
        sw = m_spec;
        for (int j = 0; j < WIDTH; j++)
          if (bus.we_i[j]) sw[bus.waddr_i[j]] = bus.wdata_i[j];
        if (bus.ckpt_req_i && size0 < CKPT_NUM) ck_q.push_back(sw);
        m_spec = sw;
      end
    end
    m_arch = an;
  endtask

  task automatic tick();
    #2;
    check_outs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0;
    bus.raddr_i = '0;
    bus.we_i = '0;
    bus.waddr_i = '0;
    bus.wdata_i = '0;
    bus.ckpt_req_i = 1'b0;
    bus.ckpt_rel_i = 1'b0;
    bus.restore_i = 1'b0;
    bus.restore_id_i = '0;
    bus.flush_i = 1'b0;
    bus.cmt_we_i = '0;
    bus.cmt_waddr_i = '0;
    bus.cmt_wdata_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_random();
    int sz, off;
    idle_inputs();
    for (int k = 0; k < WIDTH; k++) begin
      for (int s = 0; s < 2; s++) bus.raddr_i[k][s] = 5'($urandom_range(0, 7));
      bus.we_i[k]        = ($urandom % 4) != 0;
      bus.waddr_i[k]     = 5'($urandom_range(0, 7));
      bus.wdata_i[k]     = 7'($urandom);
      bus.cmt_we_i[k]    = ($urandom % 3) == 0;
      bus.cmt_waddr_i[k] = 5'($urandom_range(0, 7));
      bus.cmt_wdata_i[k] = 7'($urandom);
    end
    bus.ckpt_req_i = ($urandom % 3) == 0;
    bus.ckpt_rel_i = ($urandom % 5) == 0;
    sz = ck_q.size();
    if (sz > 0 && ($urandom % 10) == 0) begin
      bus.restore_i = 1'b1;
      if (bus.ckpt_rel_i && sz >= 2) off = $urandom_range(1, sz - 1);
      else begin
        bus.ckpt_rel_i = 1'b0;
        off = $urandom_range(0, sz - 1);
      end
      bus.restore_id_i = 2'((ck_head + off) % CKPT_NUM);
    end
    bus.flush_i = ($urandom % 25) == 0;
    rst = ($urandom % 150) == 0;
  endtask

  int busy_cnt;

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;

    // identity map after reset
    bus.raddr_i[0][0] = 5'd5;
    bus.waddr_i[0] = 5'd3;
    #1;
    chk("t1_r5", 32'(bus.rdata_o[0][0]), 32'd5);
    chk("t1_old3", 32'(bus.old_o[0]), 32'd3);
    chk("t1_ready", 32'(bus.ckpt_ready_o), 32'd1);
    chk("t1_busy", 32'(bus.busy_o), 32'd0);
    tick();

    // intra-group forwarding and same-areg write priority
    idle_inputs();
    bus.we_i = 2'b11;
    bus.waddr_i[0] = 5'd3; bus.wdata_i[0] = 7'd40;
    bus.waddr_i[1] = 5'd3; bus.wdata_i[1] = 7'd41;
    bus.raddr_i[1][0] = 5'd3;
    #1;
    chk("t2_fwd", 32'(bus.rdata_o[1][0]), 32'd40);
    chk("t2_old1", 32'(bus.old_o[1]), 32'd40);
    tick();
    idle_inputs();
    bus.raddr_i[0][0] = 5'd3;
    #1;
    chk("t2_r3", 32'(bus.rdata_o[0][0]), 32'd41);
    tick();

    // checkpoint then mispredict restore
    idle_inputs();
    bus.we_i[0] = 1'b1; bus.waddr_i[0] = 5'd7; bus.wdata_i[0] = 7'd50;
    bus.ckpt_req_i = 1'b1;
    #1;
    chk("t3_id0", 32'(bus.ckpt_id_o), 32'd0);
    tick();
    idle_inputs();
    bus.we_i[0] = 1'b1; bus.waddr_i[0] = 5'd7; bus.wdata_i[0] = 7'd60;
    tick();
    idle_inputs();
    bus.restore_i = 1'b1; bus.restore_id_i = 2'd0;
    bus.we_i[0] = 1'b1; bus.waddr_i[0] = 5'd7; bus.wdata_i[0] = 7'd99;
    tick();
    idle_inputs();
    bus.raddr_i[0][0] = 5'd7;
    #1;
    chk("t3_busy1", 32'(bus.busy_o), 32'd1);
    tick();
    #1;
    chk("t3_busy0", 32'(bus.busy_o), 32'd0);
    chk("t3_r7", 32'(bus.rdata_o[0][0]), 32'd50);
    chk("t3_tail", 32'(bus.ckpt_id_o), 32'd1);
    tick();

    // fill the FIFO, drop a request, release and wrap
    do_reset();
    bus.ckpt_req_i = 1'b1;
    for (int i = 0; i < CKPT_NUM; i++) tick();
    #1;
    chk("t4_full", 32'(bus.ckpt_ready_o), 32'd0);
    tick();
    #1;
    chk("t4_drop_id", 32'(bus.ckpt_id_o), 32'd0);
    bus.ckpt_req_i = 1'b0;
    bus.ckpt_rel_i = 1'b1;
    tick();
    bus.ckpt_rel_i = 1'b0;
    #1;
    chk("t4_ready", 32'(bus.ckpt_ready_o), 32'd1);
    chk("t4_wrap_id", 32'(bus.ckpt_id_o), 32'd0);
    tick();

    // flush from arch RAT, then flush with a same-cycle commit
    do_reset();
    bus.cmt_we_i[0] = 1'b1; bus.cmt_waddr_i[0] = 5'd2; bus.cmt_wdata_i[0] = 7'd70;
    tick();
    idle_inputs();
    bus.we_i[1] = 1'b1; bus.waddr_i[1] = 5'd2; bus.wdata_i[1] = 7'd80;
    bus.ckpt_req_i = 1'b1;
    tick();
    idle_inputs();
    bus.flush_i = 1'b1;
    tick();
    idle_inputs();
    bus.raddr_i[0][0] = 5'd2;
    #1;
    chk("t5_r2", 32'(bus.rdata_o[0][0]), 32'd70);
    chk("t5_cnt0", 32'(bus.ckpt_id_o), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    bus.flush_i = 1'b1;
    bus.cmt_we_i[1] = 1'b1; bus.cmt_waddr_i[1] = 5'd2; bus.cmt_wdata_i[1] = 7'd71;
    tick();
    idle_inputs();
    bus.raddr_i[0][0] = 5'd2;
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bus.busy_o) busy_cnt++;
      tick();
    end
`ifdef RAT_FLUSH_CMT_BYPASS_EN
    chk("t5_busy_cycles", 32'(busy_cnt), 32'd1);
`else
    chk("t5_busy_cycles", 32'(busy_cnt), 32'd2);
`endif
    #1;
    chk("t5_r2_71", 32'(bus.rdata_o[0][0]), 32'd71);
    tick();

    // flush beats restore; reset during recovery
    do_reset();
    bus.we_i[0] = 1'b1; bus.waddr_i[0] = 5'd9; bus.wdata_i[0] = 7'd90;
    bus.ckpt_req_i = 1'b1;
    tick();
    idle_inputs();
    bus.flush_i = 1'b1; bus.restore_i = 1'b1; bus.restore_id_i = 2'd0;
    tick();
    idle_inputs();
    bus.raddr_i[0][0] = 5'd9;
    for (int i = 0; i < 3; i++) tick();
    #1;
    chk("t6_r9", 32'(bus.rdata_o[0][0]), 32'd9);
    bus.we_i[0] = 1'b1; bus.waddr_i[0] = 5'd4; bus.wdata_i[0] = 7'd44;
    bus.ckpt_req_i = 1'b1;
    tick();
    idle_inputs();
    bus.restore_i = 1'b1; bus.restore_id_i = 2'd0;
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    idle_inputs();
    bus.raddr_i[0][0] = 5'd4;
    #1;
    chk("t6_rst_busy", 32'(bus.busy_o), 32'd0);
    chk("t6_rst_r4", 32'(bus.rdata_o[0][0]), 32'd4);
    chk("t6_rst_ready", 32'(bus.ckpt_ready_o), 32'd1);
    tick();

    // randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
